// File: rtl/inscache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: geometry default,
// controller state encoding and address helpers.
package inscache_pkg;

    localparam int IC_IDX_W = 6;

    typedef enum logic {
        IC_IDLE = 1'b0,
        IC_MISS = 1'b1
    } ic_state_e;

    // Word address: the byte offset bits of a PC carry no information here.
    function automatic logic [29:0] word_addr(input logic [31:0] pc);
        return pc[31:2];
    endfunction

endpackage

// File: rtl/inscache_store.sv
// Line storage for inscache: valid/tag/data arrays, one combinational read port
// by index and one synchronous write port. Only the valid bits are reset.
module inscache_store
    import inscache_pkg::*;
#(
    parameter int IDX_W = IC_IDX_W
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic                rd_valid,
    output logic [29-IDX_W:0]   rd_tag,
    output logic [31:0]         rd_data,
    input  logic                we,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [29-IDX_W:0]   wr_tag,
    input  logic [31:0]         wr_data
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data contents are meaningless until the matching valid bit is set.
    always_ff @(posedge clk_in) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/inscache.sv
// Direct-mapped instruction cache: same-cycle hits, single outstanding word
// miss to memctrl with bypass of the returning word, flush and stall aware.
module inscache
    import inscache_pkg::*;
#(
    parameter int IDX_W = IC_IDX_W
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        ifetch_valid,
    input  logic [31:0] ifetch_pc,
    output logic        ins_ready,
    output logic [31:0] ins_out,
    output logic        is_fetch,
    output logic [31:0] fetch_addr,
    input  logic        is_back,
    input  logic [31:0] back_ins
);

    localparam int TAG_W = 30 - IDX_W;

    ic_state_e   state_q, state_d;
    logic [29:0] miss_pc_q, miss_pc_d;
    logic        is_fetch_q, is_fetch_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] pc_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             fill_we;
    logic             hit;
    logic             unused_pc_bits;

    assign idx            = ifetch_pc[IDX_W+1:2];
    assign pc_tag         = ifetch_pc[31:IDX_W+2];
    assign unused_pc_bits = ^ifetch_pc[1:0];

    inscache_store #(.IDX_W(IDX_W)) u_store (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (fill_we),
        .wr_idx   (miss_pc_q[IDX_W-1:0]),
        .wr_tag   (miss_pc_q[29:IDX_W]),
        .wr_data  (back_ins)
    );

    assign hit = rdy_in && ifetch_valid && rd_valid && (rd_tag == pc_tag);

    always_comb begin
        state_d      = state_q;
        miss_pc_d    = miss_pc_q;
        is_fetch_d   = is_fetch_q;
        fetch_addr_d = fetch_addr_q;
        fill_we      = 1'b0;
        ins_ready    = 1'b0;
        ins_out      = rd_data;

        // A flush wins over everything, including a coincident is_back.
        if (rdy_in && rob_clear) begin
            state_d    = IC_IDLE;
            is_fetch_d = 1'b0;
        end else if (rdy_in) begin
            case (state_q)
                IC_IDLE: begin
                    if (hit) begin
                        ins_ready = 1'b1;
                    end else if (ifetch_valid) begin
                        state_d      = IC_MISS;
                        miss_pc_d    = word_addr(ifetch_pc);
                        fetch_addr_d = {word_addr(ifetch_pc), 2'b00};
                        is_fetch_d   = 1'b1;
                    end
                end
                IC_MISS: begin
                    if (is_back) begin
                        fill_we    = 1'b1;
                        is_fetch_d = 1'b0;
                        state_d    = IC_IDLE;
                        if (ifetch_valid && (word_addr(ifetch_pc) == miss_pc_q)) begin
                            ins_ready = 1'b1;
                            ins_out   = back_ins;
                        end
                    end
                end
                default: begin
                    state_d = IC_IDLE;
                end
            endcase
        end

        if (!rst_in) begin
            ins_ready = 1'b0;
            ins_out   = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IC_IDLE;
            miss_pc_q    <= '0;
            is_fetch_q   <= 1'b0;
            fetch_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            miss_pc_q    <= miss_pc_d;
            is_fetch_q   <= is_fetch_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    assign is_fetch   = is_fetch_q;
    assign fetch_addr = fetch_addr_q;

endmodule

// File: tb/tb_inscache.sv
// Bench for inscache: directed miss/hit/flush/stall/reset scenarios, then random
// fetches against a line-map model with an auto-responding memctrl.
module tb_inscache;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        ifetch_valid;
    logic [31:0] ifetch_pc;
    logic        ins_ready;
    logic [31:0] ins_out;
    logic        is_fetch;
    logic [31:0] fetch_addr;
    logic        is_back;
    logic [31:0] back_ins;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_q[$];

    // Reference model: which word address each line currently holds.
    bit          m_valid [64];
    logic [29:0] m_addr  [64];
    bit          auto_mem = 0;

    inscache dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rob_clear    (rob_clear),
        .ifetch_valid (ifetch_valid),
        .ifetch_pc    (ifetch_pc),
        .ins_ready    (ins_ready),
        .ins_out      (ins_out),
        .is_fetch     (is_fetch),
        .fetch_addr   (fetch_addr),
        .is_back      (is_back),
        .back_ins     (back_ins)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, expv);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_in);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_0100) return 32'h0050_0093;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[pc[7:2]] && (m_addr[pc[7:2]] == pc[31:2]);
    endfunction

    task automatic model_fill(input logic [31:0] pc);
        m_valid[pc[7:2]] = 1'b1;
        m_addr[pc[7:2]]  = pc[31:2];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    // Full directed miss: request, fetch issue, hold, is_back with bypass, fetch drop.
    task automatic miss_fill(input logic [31:0] pc);
        exp_q.push_back(mem_word(pc));
        ifetch_valid = 1'b1;
        ifetch_pc    = pc;
        smp();
        chk("mf_miss_ready", {31'd0, ins_ready}, 32'd0);
        step();
        smp();
        chk("mf_is_fetch", {31'd0, is_fetch}, 32'd1);
        chk("mf_fetch_addr", fetch_addr, {pc[31:2], 2'b00});
        repeat (2) step();
        smp();
        chk("mf_fetch_hold", {31'd0, is_fetch}, 32'd1);
        step();
        is_back  = 1'b1;
        back_ins = mem_word(pc);
        smp();
        chk("mf_bypass_ready", {31'd0, ins_ready}, 32'd1);
        step();
        is_back      = 1'b0;
        ifetch_valid = 1'b0;
        smp();
        chk("mf_fetch_low", {31'd0, is_fetch}, 32'd0);
        model_fill(pc);
    endtask

    // ---------------- memctrl responder ----------------
    initial begin
        int  cnt;
        bit  busy;
        busy = 0;
        cnt  = 0;
        forever begin
            @(posedge clk_in);
            #1;
            if (auto_mem) begin
                if (is_back) begin
                    is_back = 1'b0;
                end else if (is_fetch && !busy) begin
                    busy = 1;
                    cnt  = $urandom_range(6, 9);
                end else if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        is_back  = 1'b1;
                        back_ins = mem_word(fetch_addr);
                        busy     = 0;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_in) begin
        if (rst_in && ins_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ready: got ins_ready=1 with ins_out %h, expected no response", ins_out);
            end else begin
                chk("ins_out", ins_out, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pc;
        bit          h;
        bit          got;

        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        rob_clear    = 1'b0;
        ifetch_valid = 1'b1;
        ifetch_pc    = 32'h0000_0100;
        is_back      = 1'b0;
        back_ins     = 32'd0;
        model_clear();

        repeat (2) smp();
        chk("rst_ins_ready", {31'd0, ins_ready}, 32'd0);
        chk("rst_ins_out", ins_out, 32'd0);
        chk("rst_is_fetch", {31'd0, is_fetch}, 32'd0);
        chk("rst_fetch_addr", fetch_addr, 32'd0);
        step();
        rst_in       = 1'b1;
        ifetch_valid = 1'b0;
        step();

        // First miss and fill of 0x100, then a same-cycle hit.
        miss_fill(32'h0000_0100);
        step();
        exp_q.push_back(mem_word(32'h0000_0100));
        ifetch_valid = 1'b1;
        ifetch_pc    = 32'h0000_0100;
        smp();
        chk("hit_ready", {31'd0, ins_ready}, 32'd1);
        step();
        ifetch_valid = 1'b0;
        smp();
        chk("hit_no_fetch", {31'd0, is_fetch}, 32'd0);

        // Conflict: 0x200 evicts 0x100.
        step();
        miss_fill(32'h0000_0200);
        step();
        ifetch_valid = 1'b1;
        ifetch_pc    = 32'h0000_0100;
        smp();
        chk("conflict_miss", {31'd0, ins_ready}, 32'd0);
        step();
        smp();
        chk("conflict_fetch", {31'd0, is_fetch}, 32'd1);
        chk("conflict_addr", fetch_addr, 32'h0000_0100);

        // Flush mid-miss, then a late is_back in IDLE.
        step();
        rob_clear    = 1'b1;
        ifetch_valid = 1'b0;
        step();
        rob_clear = 1'b0;
        smp();
        chk("clr_fetch_low", {31'd0, is_fetch}, 32'd0);
        step();
        is_back  = 1'b1;
        back_ins = 32'hDEAD_BEEF;
        smp();
        chk("late_back_ready", {31'd0, ins_ready}, 32'd0);
        step();
        is_back      = 1'b0;
        ifetch_valid = 1'b1;
        ifetch_pc    = 32'h0000_0100;
        smp();
        chk("refetch_miss", {31'd0, ins_ready}, 32'd0);
        step();
        smp();
        chk("refetch_fetch", {31'd0, is_fetch}, 32'd1);
        chk("refetch_addr", fetch_addr, 32'h0000_0100);

        // is_back coincident with flush: no fill, old line survives.
        step();
        is_back   = 1'b1;
        back_ins  = mem_word(32'h0000_0100);
        rob_clear = 1'b1;
        smp();
        chk("clr_back_ready", {31'd0, ins_ready}, 32'd0);
        step();
        is_back      = 1'b0;
        rob_clear    = 1'b0;
        ifetch_valid = 1'b0;
        smp();
        chk("clr_back_fetch", {31'd0, is_fetch}, 32'd0);
        step();
        ifetch_valid = 1'b1;
        ifetch_pc    = 32'h0000_0200;
        rob_clear    = 1'b1;
        smp();
        chk("clr_hit_forced", {31'd0, ins_ready}, 32'd0);
        step();
        rob_clear = 1'b0;
        exp_q.push_back(mem_word(32'h0000_0200));
        smp();
        chk("hit_200", {31'd0, ins_ready}, 32'd1);
        step();
        ifetch_pc = 32'h0000_0100;
        smp();
        chk("nofill_miss", {31'd0, ins_ready}, 32'd0);
        step();
        smp();
        chk("nofill_fetch", {31'd0, is_fetch}, 32'd1);

        // Stall with is_back held: consumed on the first ready cycle.
        step();
        rdy_in   = 1'b0;
        is_back  = 1'b1;
        back_ins = mem_word(32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("stall_ready", {31'd0, ins_ready}, 32'd0);
            chk("stall_fetch", {31'd0, is_fetch}, 32'd1);
            step();
        end
        rdy_in = 1'b1;
        exp_q.push_back(mem_word(32'h0000_0100));
        smp();
        chk("stall_bypass", {31'd0, ins_ready}, 32'd1);
        step();
        is_back      = 1'b0;
        ifetch_valid = 1'b0;
        model_fill(32'h0000_0100);
        smp();
        chk("stall_fetch_low", {31'd0, is_fetch}, 32'd0);
        step();
        ifetch_valid = 1'b1;
        ifetch_pc    = 32'h0000_0103;
        exp_q.push_back(mem_word(32'h0000_0100));
        smp();
        chk("post_stall_hit", {31'd0, ins_ready}, 32'd1);

        // Asynchronous reset in the middle of a miss.
        step();
        ifetch_pc = 32'h0000_0300;
        smp();
        chk("rst_pre_miss", {31'd0, ins_ready}, 32'd0);
        step();
        smp();
        chk("rst_pre_fetch", {31'd0, is_fetch}, 32'd1);
        #1;
        rst_in = 1'b0;
        #1;
        chk("arst_is_fetch", {31'd0, is_fetch}, 32'd0);
        chk("arst_fetch_addr", fetch_addr, 32'd0);
        chk("arst_ins_ready", {31'd0, ins_ready}, 32'd0);
        chk("arst_ins_out", ins_out, 32'd0);
        model_clear();
        step();
        rst_in    = 1'b1;
        ifetch_pc = 32'h0000_0100;
        smp();
        chk("post_rst_miss", {31'd0, ins_ready}, 32'd0);
        step();
        ifetch_valid = 1'b0;
        rob_clear    = 1'b1;
        step();
        rob_clear = 1'b0;
        smp();
        chk("post_rst_idle", {31'd0, is_fetch}, 32'd0);

        // Random fetches against the line-map model.
        auto_mem = 1;
        for (int i = 0; i < 150; i++) begin
            step();
            pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            h  = model_hit(pc);
            exp_q.push_back(mem_word(pc));
            ifetch_valid = 1'b1;
            ifetch_pc    = pc;
            smp();
            chk("rnd_fetch_idle", {31'd0, is_fetch}, 32'd0);
            chk("rnd_hit", {31'd0, ins_ready}, {31'd0, h});
            if (!h) begin
                step();
                smp();
                chk("rnd_fetch", {31'd0, is_fetch}, 32'd1);
                chk("rnd_fetch_addr", fetch_addr, {pc[31:2], 2'b00});
                got = 0;
                for (int c = 0; c < 40 && !got; c++) begin
                    step();
                    smp();
                    if (ins_ready) got = 1;
                end
                chk("rnd_miss_done", {31'd0, got}, 32'd1);
                model_fill(pc);
            end
            if ($urandom_range(0, 3) == 0) begin
                step();
                ifetch_valid = 1'b0;
            end
        end

        step();
        ifetch_valid = 1'b0;
        repeat (3) step();
        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
